platform_seg7_display_ctrl: RTL and testbench
=============================================

// Module: platform_seg7_display_ctrl
// PURPOSE
//  Avalon-MM slave driving NUM_DIGITS seven-segment digits; parametrised successor to the single-digit 7-bit PIO.
//  Per-digit raw/hex-decode data, global polarity, per-digit blink with programmable rate.
//  Two output forms: parallel (one 7-bit field per digit) and time-multiplexed scan (shared segments + one-hot digit select).
//  Sits on the platform Avalon bus beside the other PIOs; outputs go straight to board pins.
// PARAMETERS
//  NUM_DIGITS  6       number of digits, 1..8
//  ADDR_W      4       Avalon word address width (must cover addr 0..9)
//  BLINK_W     24      width of blink divider register/counter
//  BLINK_RST   24'd12_500_000  reset value of BLINK_DIV register
//  SCAN_DIV    50000   clk cycles per scan digit slot, >=1
// PORTS
//  clk        in   1              system clock
//  reset_n    in   1              asynchronous, active-low reset
//  address    in   ADDR_W         word address
//  chipselect in   1              slave select
//  write_n    in   1              active-low write strobe
//  writedata  in   32             write data
//  readdata   out  32             read data, combinational, zero wait states
//  out_port   out  7*NUM_DIGITS   parallel segments, digit i at [7i+6:7i], bit order gfedcba
//  seg_o      out  7              scanned segments for digit selected by dig_sel
//  dig_sel    out  NUM_DIGITS     one-hot active-high scan digit select
// BEHAVIOUR
//  Write = chipselect & ~write_n; takes effect on next clk edge. Unmapped addresses: writes ignored, reads 0.
//  Map: addr i (i<NUM_DIGITS) DIGIT[i] = writedata[6:0]; addr 8 CTRL; addr 9 BLINK_DIV. Unused read bits 0.
//  CTRL: [0] DECODE (1: low nibble of DIGIT -> hex glyph); [1] INVERT (active-low pins); [15:8] BLINK_MASK (bit i blinks digit i; bits >= NUM_DIGITS read 0).
//  Reset: DIGIT[*]=0, CTRL=0, BLINK_DIV=BLINK_RST, blink counter 0, phase=visible, out_port=0, scan slot 0, dig_sel=1, seg_o=0.
//  Glyphs 0-F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71 (active-high).
//  Per digit: v = DECODE ? glyph(DIGIT[3:0]) : DIGIT; blank -> v=0; final = INVERT ? ~v : v.
//  out_port is registered: a write is visible on out_port exactly 1 cycle after the write edge.
//  Blink: counter increments each clk; when counter==BLINK_DIV it wraps to 0 and phase toggles.
//   digit blanked when BLINK_MASK[i] & phase==hidden. BLINK_DIV==0: counter held 0, phase forced visible.
//   Any write to BLINK_DIV clears counter and sets phase=visible in the same edge.
//  Scan: slot counter counts 0..SCAN_DIV-1; on terminal count, slot advances i -> i+1, NUM_DIGITS-1 -> 0.
//   dig_sel and seg_o registered together; seg_o always equals the out_port field of the digit selected by dig_sel, one cycle later (both registered from the same source).
//   NUM_DIGITS==1: dig_sel constant 1.
//  Simultaneous: a write and a blink toggle on the same edge both apply; BLINK_DIV write takes priority over toggle.
//  Reset asserted mid-operation: all state returns to reset values asynchronously; no partial writes retained.
// TESTING
//  Reset -> out_port=0, dig_sel=6'b000001, seg_o=0, read addr 9 = 12_500_000.
//  Write DIGIT[2]=0x5B, DECODE=0 -> out_port[20:14]=0x5B one cycle later; read addr 2 = 0x5B; read addr 12 = 0.
//  CTRL=0x3 (decode+invert), DIGIT[0]=0xA -> out_port[6:0]=~0x77=0x08; DIGIT[0]=0x1F -> glyph F, ~0x71=0x0E.
//  BLINK_DIV=3, CTRL[15:8]=0x01, DIGIT[0]=0x7F -> out_port[6:0] alternates 0x7F/0x00 every 4 cycles; DIGIT[1] unaffected.
//  SCAN_DIV=2 bench, NUM_DIGITS=6 -> dig_sel steps 1,2,4,..,32,1 every 2 cycles; seg_o matches selected out_port field.
//  Assert reset_n mid-blink and mid-scan -> all outputs/registers return to reset values without waiting for clk.

Source files
------------

// File: rtl/platform_seg7_display_ctrl_if.sv
// Avalon-MM slave port bundle for the seven-segment display controller.
interface platform_seg7_display_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/platform_seg7_display_ctrl.sv
// Multi-digit seven-segment controller: per-digit raw/hex data, polarity, blink, parallel and scanned outputs.
// Writes land on the next edge and reach out_port one edge later; zero-wait reads, no backpressure.
module platform_seg7_display_ctrl #(
  parameter int                 NUM_DIGITS = 6,
  parameter int                 ADDR_W     = 4,
  parameter int                 BLINK_W    = 24,
  parameter logic [BLINK_W-1:0] BLINK_RST  = BLINK_W'(12_500_000),
  parameter int                 SCAN_DIV   = 50000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  platform_seg7_display_ctrl_if.slave bus,
  output logic [7*NUM_DIGITS-1:0]     out_port,
  output logic [6:0]                  seg_o,
  output logic [NUM_DIGITS-1:0]       dig_sel
);

  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {PH_VISIBLE = 1'b0, PH_HIDDEN = 1'b1} phase_e;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  function automatic logic [6:0] pixel(input logic [6:0] d, input logic dec, input logic inv,
                                       input logic blank);
    logic [6:0] v;
    v = dec ? glyph(d[3:0]) : d;
    if (blank) v = '0;
    pixel = inv ? ~v : v;
  endfunction

  logic                    wr_en, wr_div;
  logic [6:0]              digit_q [NUM_DIGITS];
  logic [6:0]              digit_d [NUM_DIGITS];
  logic                    decode_q, decode_d, invert_q, invert_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic [BLINK_W-1:0]      div_q, div_d, bcnt_q, bcnt_d;
  phase_e                  phase_q, phase_d;
  logic [7*NUM_DIGITS-1:0] out_q, out_d;
  logic [SCAN_W-1:0]       scnt_q, scnt_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    unused_wdat;

  assign wr_en       = bus.chipselect & ~bus.write_n;
  assign wr_div      = wr_en && (bus.address == ADDR_W'(9));
  assign unused_wdat = ^bus.writedata;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = digit_q[i];
    decode_d = decode_q;
    invert_d = invert_q;
    mask_d   = mask_q;
    div_d    = div_q;
    if (wr_en) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (bus.address == ADDR_W'(i)) digit_d[i] = bus.writedata[6:0];
      if (bus.address == ADDR_W'(8)) begin
        decode_d = bus.writedata[0];
        invert_d = bus.writedata[1];
        mask_d   = bus.writedata[8 +: NUM_DIGITS];
      end
      if (wr_div) div_d = bus.writedata[BLINK_W-1:0];
    end
  end

  // A divider write restarts the blink period, overriding any toggle due this edge.
  always_comb begin
    bcnt_d  = bcnt_q + BLINK_W'(1);
    phase_d = phase_q;
    if (wr_div || (div_q == '0)) begin
      bcnt_d  = '0;
      phase_d = PH_VISIBLE;
    end else if (bcnt_q == div_q) begin
      bcnt_d  = '0;
      phase_d = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
    end
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      out_d[7*i +: 7] = pixel(digit_q[i], decode_q, invert_q,
                              mask_q[i] && (phase_q == PH_HIDDEN));
  end

  // Select and segments are both taken from slot_q/out_q so they always stay paired.
  always_comb begin
    scnt_d = scnt_q + SCAN_W'(1);
    slot_d = slot_q;
    if (scnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scnt_d = '0;
      slot_d = (slot_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_q + SLOT_W'(1);
    end
    seg_d = '0;
    sel_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (slot_q == SLOT_W'(i)) begin
        sel_d[i] = 1'b1;
        seg_d    = out_q[7*i +: 7];
      end
  end

  always_comb begin
    bus.readdata = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bus.address == ADDR_W'(i)) bus.readdata[6:0] = digit_q[i];
    if (bus.address == ADDR_W'(8)) begin
      bus.readdata[0]               = decode_q;
      bus.readdata[1]               = invert_q;
      bus.readdata[8 +: NUM_DIGITS] = mask_q;
    end
    if (bus.address == ADDR_W'(9)) bus.readdata[BLINK_W-1:0] = div_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
      decode_q <= 1'b0;
      invert_q <= 1'b0;
      mask_q   <= '0;
      div_q    <= BLINK_RST;
      bcnt_q   <= '0;
      phase_q  <= PH_VISIBLE;
      out_q    <= '0;
      scnt_q   <= '0;
      slot_q   <= '0;
      seg_q    <= '0;
      sel_q    <= NUM_DIGITS'(1);
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
      decode_q <= decode_d;
      invert_q <= invert_d;
      mask_q   <= mask_d;
      div_q    <= div_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      out_q    <= out_d;
      scnt_q   <= scnt_d;
      slot_q   <= slot_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
    end
  end

  assign out_port = out_q;
  assign seg_o    = seg_q;
  assign dig_sel  = sel_q;

endmodule

// File: tb/tb_platform_seg7_display_ctrl.sv
// Bench for the seven-segment controller: vector table, hand sequences and random traffic against a model.
module tb_platform_seg7_display_ctrl;
  localparam int N = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  platform_seg7_display_ctrl_if #(.ADDR_W(4)) bus ();
  logic [7*N-1:0] out_port;
  logic [6:0]     seg_o;
  logic [N-1:0]   dig_sel;

  platform_seg7_display_ctrl #(
    .NUM_DIGITS(N), .ADDR_W(4), .BLINK_W(24), .BLINK_RST(24'd12_500_000), .SCAN_DIV(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .out_port(out_port), .seg_o(seg_o), .dig_sel(dig_sel)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0]  gly [16];
  logic [6:0]  m_dig [N];
  logic        m_dec, m_inv;
  logic [N-1:0] m_mask;
  int unsigned m_div, m_k, m_m;
  logic [7*N-1:0] m_out;
  logic [6:0]  exp_seg;
  logic [N-1:0] exp_sel;

  typedef struct {
    logic [3:0]  wa;
    logic [31:0] wd;
    int          fld;
    logic [6:0]  exp_fld;
    logic [3:0]  ra;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vt [9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_dig[i] = '0;
    m_dec = 1'b0; m_inv = 1'b0; m_mask = '0;
    m_div = 12_500_000; m_k = 0; m_m = 0; m_out = '0;
  endtask

  // Display image from the register file and the number of edges since the blink period restarted.
  function automatic logic [7*N-1:0] model_pix();
    logic [7*N-1:0] r;
    logic           hidden;
    logic [6:0]     v;
    hidden = (m_div != 0) && (((m_k / (m_div + 1)) % 2) == 1);
    r = '0;
    for (int i = 0; i < N; i++) begin
      v = m_dec ? gly[m_dig[i][3:0]] : m_dig[i];
      if (m_mask[i] && hidden) v = '0;
      if (m_inv) v = ~v;
      r[7*i +: 7] = v;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input int a);
    if (a < N) return {25'd0, m_dig[a]};
    if (a == 8) return {16'd0, 2'd0, m_mask, 6'd0, m_inv, m_dec};
    if (a == 9) return m_div;
    return 32'd0;
  endfunction

  task automatic tick();
    logic [7*N-1:0] nxt;
    int             sp, a;
    logic           w;
    logic [31:0]    d;
    nxt = model_pix();
    sp  = (m_m / 2) % N;
    w   = bus.chipselect && !bus.write_n;
    a   = int'(bus.address);
    d   = bus.writedata;
    @(posedge clk);
    exp_seg = m_out[7*sp +: 7];
    exp_sel = N'(1 << sp);
    m_out   = nxt;
    m_k++;
    m_m++;
    if (w) begin
      if (a < N) m_dig[a] = d[6:0];
      else if (a == 8) begin
        m_dec = d[0]; m_inv = d[1]; m_mask = d[8 +: N];
      end else if (a == 9) begin
        m_div = d[23:0]; m_k = 0;
      end
    end
    @(negedge clk);
    check("out_port", out_port, m_out);
    check("dig_sel", dig_sel, exp_sel);
    check("seg_o", seg_o, exp_seg);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd_check(input string nm, input logic [3:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    check(nm, bus.readdata, exp);
  endtask

  logic [6:0]   bs [24];
  logic [N-1:0] ss [14];

  initial begin
    gly = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vt[0] = '{4'd2,  32'h5B,   2, 7'h5B, 4'd2,  32'h5B};
    vt[1] = '{4'd12, 32'hFF,   2, 7'h5B, 4'd12, 32'h0};
    vt[2] = '{4'd8,  32'h3,    2, 7'h03, 4'd8,  32'h3};
    vt[3] = '{4'd0,  32'hA,    0, 7'h08, 4'd0,  32'hA};
    vt[4] = '{4'd0,  32'h1F,   0, 7'h0E, 4'd0,  32'h1F};
    vt[5] = '{4'd8,  32'hFFFF, 0, 7'h0E, 4'd8,  32'h3F03};
    vt[6] = '{4'd8,  32'h0,    0, 7'h1F, 4'd8,  32'h0};
    vt[7] = '{4'd9,  32'h0,    0, 7'h1F, 4'd9,  32'h0};
    vt[8] = '{4'd7,  32'h55,   2, 7'h5B, 4'd7,  32'h0};

    bus.address = '0; bus.writedata = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    model_reset();
    #2 reset_n = 1'b0;
    #2;
    check("rst_out_port", out_port, 42'd0);
    check("rst_dig_sel", dig_sel, 6'b000001);
    check("rst_seg_o", seg_o, 7'd0);
    rd_check("rst_blink_div", 4'd9, 32'd12_500_000);
    rd_check("rst_digit0", 4'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      do_write(vt[v].wa, vt[v].wd);
      rd_check("tbl_rd", vt[v].ra, vt[v].exp_rd);
      tick();
      check("tbl_fld", out_port[7*vt[v].fld +: 7], vt[v].exp_fld);
    end

    do_write(4'd4, 32'h12);
    check("lat_before", out_port[34:28], 7'h00);
    tick();
    check("lat_after", out_port[34:28], 7'h12);

    do_write(4'd9, 32'd3);
    do_write(4'd8, 32'h0100);
    do_write(4'd0, 32'h7F);
    do_write(4'd1, 32'h22);
    for (int j = 0; j < 24; j++) begin
      tick();
      bs[j] = out_port[6:0];
      check("blink_val", ((bs[j] == 7'h7F) || (bs[j] == 7'h00)) ? 1 : 0, 1);
      check("blink_other", out_port[13:7], 7'h22);
      if (j >= 4) check("blink_alt", (bs[j] != bs[j-4]) ? 1 : 0, 1);
    end

    for (int j = 0; j < 14; j++) begin
      tick();
      ss[j] = dig_sel;
      if (j >= 2) check("scan_step", ss[j], {ss[j-2][N-2:0], ss[j-2][N-1]});
    end

    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_port", out_port, 42'd0);
    check("mid_rst_dig_sel", dig_sel, 6'b000001);
    check("mid_rst_seg_o", seg_o, 7'd0);
    rd_check("mid_rst_div", 4'd9, 32'd12_500_000);
    rd_check("mid_rst_ctrl", 4'd8, 32'd0);
    rd_check("mid_rst_digit0", 4'd0, 32'd0);
    bus.address = 4'd3; bus.writedata = 32'h44; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    rd_check("rst_write_dropped", 4'd3, 32'd0);
    model_reset();
    reset_n = 1'b1;
    bus.address = '0;

    for (int it = 0; it < 400; it++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      bus.address    = a;
      bus.writedata  = (a == 4'd9) ? 32'($urandom_range(0, 5)) : $urandom;
      bus.chipselect = ($urandom_range(0, 3) != 0);
      bus.write_n    = ($urandom_range(0, 3) == 0);
      tick();
      a = 4'($urandom_range(0, 15));
      rd_check("rand_rd", a, model_rd(int'(a)));
    end
    bus.chipselect = 1'b0; bus.write_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
